// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// md_unit : HI/LO multiply/divide sequencer for the E stage of the MIPS core
// Rev 1.0
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        M_in_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] C_OP_MULT  = 3'd1;
  localparam logic [2:0] C_OP_MULTU = 3'd2;
  localparam logic [2:0] C_OP_DIV   = 3'd3;
  localparam logic [2:0] C_OP_DIVU  = 3'd4;
  localparam logic [2:0] C_OP_MTHI  = 3'd5;
  localparam logic [2:0] C_OP_MTLO  = 3'd6;

  localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        nowrite_q, nowrite_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_divisor;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_mag_q;
  logic [31:0] w_mag_r;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic        w_b_zero;
  logic        w_md_op;

  assign w_prod_s = 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Substitute a divisor of 1 on divide-by-zero so the dividers never see 0;
  // the result is discarded through nowrite anyway.
  assign w_b_zero  = (B == 32'd0);
  assign w_divisor = w_b_zero ? 32'd1 : B;

  // Signed divide via magnitudes; INT_MIN / -1 naturally yields LO=INT_MIN, HI=0.
  assign w_abs_a = A[31] ? (32'd0 - A) : A;
  assign w_abs_b = w_divisor[31] ? (32'd0 - w_divisor) : w_divisor;
  assign w_mag_q = w_abs_a / w_abs_b;
  assign w_mag_r = w_abs_a % w_abs_b;
  assign w_sq    = (A[31] ^ w_divisor[31]) ? (32'd0 - w_mag_q) : w_mag_q;
  assign w_sr    = A[31] ? (32'd0 - w_mag_r) : w_mag_r;
  assign w_uq    = A / w_divisor;
  assign w_ur    = A % w_divisor;

  assign w_md_op = (mdop == C_OP_MULT) || (mdop == C_OP_MULTU) ||
                   (mdop == C_OP_DIV)  || (mdop == C_OP_DIVU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      res_hi_q  <= 32'd0;
      res_lo_q  <= 32'd0;
      nowrite_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      nowrite_q <= nowrite_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    nowrite_d = nowrite_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (mdop)
            C_OP_MULT: begin
              {res_hi_d, res_lo_d} = w_prod_s;
              nowrite_d = 1'b0;
              cnt_d     = C_MULT_CNT;
              state_d   = ST_RUN;
            end
            C_OP_MULTU: begin
              {res_hi_d, res_lo_d} = w_prod_u;
              nowrite_d = 1'b0;
              cnt_d     = C_MULT_CNT;
              state_d   = ST_RUN;
            end
            C_OP_DIV: begin
              res_lo_d  = w_sq;
              res_hi_d  = w_sr;
              nowrite_d = w_b_zero;
              cnt_d     = C_DIV_CNT;
              state_d   = ST_RUN;
            end
            C_OP_DIVU: begin
              res_lo_d  = w_uq;
              res_hi_d  = w_ur;
              nowrite_d = w_b_zero;
              cnt_d     = C_DIV_CNT;
              state_d   = ST_RUN;
            end
            C_OP_MTHI: hi_d = A;
            C_OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == 4'd1) begin
          if (!nowrite_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q == ST_RUN);
  assign stall = M_in_D && (busy || (start && w_md_op));
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule
`default_nettype wire
